// File: rtl/glb_opsum_reader_pkg.sv
// Shared GLB definitions: word geometry, address type and the read-engine
// state encoding. Used by the GLB, the opsum reader and the future loader.
package glb_pkg;

  localparam int unsigned GLB_WORD_BYTES = 4;
  localparam int unsigned GLB_ADDR_W     = 32;

  typedef logic [GLB_ADDR_W-1:0] glb_addr_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_FIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/glb_opsum_reader_if.sv
// GLB read port plus the outbound valid/ready word stream of the reader.
//   master : the reader (drives glb_re/glb_addr and the stream)
//   slave  : GLB + stream consumer side
interface glb_opsum_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              glb_re;
  logic [ADDR_W-1:0] glb_addr;
  logic [DATA_W-1:0] glb_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output glb_re, glb_addr, out_valid, out_data, out_last,
    input  glb_rdata, out_ready
  );

  modport slave (
    input  glb_re, glb_addr, out_valid, out_data, out_last,
    output glb_rdata, out_ready
  );

endinterface

// File: rtl/glb_opsum_reader_sync_fifo.sv
// sync_fifo: small prefetch buffer with a head read straight from storage.
// Ports: clk, rst (sync, active-high), push/wdata, pop, rdata (head, 0 when
// empty), empty, full, count.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt_q;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign empty = (cnt_q == CW'(0));
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  // Head is zeroed when empty so the stream shows no stale words.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/glb_opsum_reader.sv
// glb_opsum_reader: fetches num_words consecutive 32-bit words from the
// byte-addressed GLB starting at base_addr and streams them out.
// Ports: clk, rst (sync, active-high); start/base_addr/num_words control;
// busy, done status; bus (master) carries the GLB read port and the stream.
module glb_opsum_reader
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  glb_opsum_reader_if.master bus
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE = RD_IDLE;
  localparam logic [1:0] S_RUN  = RD_RUN;
  localparam logic [1:0] S_FIN  = RD_FIN;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  out_left_q, out_left_d;
  logic              done_q, done_d;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FCW-1:0]    fifo_count;

  logic              hs;
  logic              credit_ok;
  logic              issue;

  assign hs = !fifo_empty && bus.out_ready;

  // Room check: a read issued now lands two edges later; the same-cycle pop
  // is credited, later pops are not.
  assign credit_ok = (fifo_count + FCW'(inflight_q)) < (FCW'(FIFO_DEPTH) + FCW'(hs));
  assign issue     = (state_q == S_RUN) && (issue_left_q != CNT_W'(0)) && credit_ok;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q && (!fifo_full || hs)),
    .wdata (bus.glb_rdata),
    .pop   (hs),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          issue_left_d = num_words;
          out_left_d   = num_words;
          state_d      = (num_words == CNT_W'(0)) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d       = addr_q + ADDR_W'(GLB_WORD_BYTES);
          issue_left_d = issue_left_q - CNT_W'(1);
        end
        if (hs) begin
          out_left_d = out_left_q - CNT_W'(1);
          if (out_left_q == CNT_W'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        // A normal transfer raised done on FIN entry; a zero-length one
        // pulses it here instead.
        done_d  = !done_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      done_q       <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      done_q       <= done_d;
      inflight_q   <= issue;
    end
  end

  assign bus.glb_re    = issue;
  assign bus.glb_addr  = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.out_last  = !fifo_empty && (out_left_q == CNT_W'(1));
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: doc/glb_opsum_reader.md
# glb_opsum_reader

Read-back engine for the accelerator's global buffer (GLB). On a `start` pulse it fetches `num_words` consecutive 32-bit output-partial-sum words from the byte-addressed GLB, beginning at `base_addr` with a 4-byte stride. It streams them out over a valid/ready interface, so the host or DMA side drains results in hardware instead of through backdoor memory peeks. It sits beside `Top`'s GLB as a second read client and is started after the PE array asserts `done`.

## Interface
- `ADDR_W`, 32: GLB byte-address width.
- `DATA_W`, 32: word width; fixed at 32, four little-endian bytes per word.
- `CNT_W`, 16: width of `num_words`.
- `FIFO_DEPTH`, 2: prefetch buffer depth; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a transfer; ignored while busy.
- `base_addr`  in  ADDR_W  byte address of first word; sampled on `start`.
- `num_words`  in  CNT_W  word count; sampled on `start`.
- `glb_re`  out  1  GLB read enable.
- `glb_addr`  out  ADDR_W  GLB byte address (word = mem[a+3..a]).
- `glb_rdata`  in  32  GLB read data, valid exactly 1 cycle after `glb_re`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  32  stream word.
- `out_last`  out  1  high with the final word of a transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer completion.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE → RUN on `start` when `num_words`≠0. Latch base into the address register and the count into `issue_left` and `out_left`.
- IDLE → FIN on `start` when `num_words`=0. No GLB reads occur.
- RUN: issue `glb_re` in cycles where `issue_left`>0 and `fifo_count + inflight + pops_pending` < FIFO_DEPTH. Use the conservative form `fifo_count + inflight < FIFO_DEPTH`, with the pop credited in the same cycle.
- On each issue: `glb_addr` = current address, then address += 4 and `issue_left` −= 1.
- The `inflight` flag captures `glb_re`. The next cycle, `glb_rdata` is pushed into the FIFO.
- Output is the FIFO head. A handshake occurs when `out_valid && out_ready`; it pops the FIFO and decrements `out_left`.
- `out_last` = `out_valid && out_left==1`.
- RUN → FIN on the handshake with `out_left==1`.
- FIN: `done`=1 for one cycle, then → IDLE.
- Address arithmetic is modulo 2^ADDR_W; it wraps silently.
- `start` in RUN or FIN is ignored and does not alter latched values.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Reset mid-transfer:
  - FIFO, counters and FSM clear next edge.
  - A GLB response already in flight is discarded.
  - No `done` is issued.

## Timing
- Reset values:
  - `glb_re`=0, `glb_addr`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `busy`=0, `done`=0.
  - Internal FIFO empty, FSM=IDLE.
- `start` at cycle T: first `glb_re` at T+1, first `out_valid` at T+3 (read at T+1, data pushed at T+2, registered head visible T+3).
- With `out_ready` held high: sustained 1 word/cycle. N words → last handshake at T+N+2, `done` at T+N+3.
- `num_words`=0: `done` at T+2, `busy` high only at T+1.
- `busy` is high from T+1 through the FIN cycle inclusive.
- Backpressure: `glb_re` never issues when the FIFO plus the in-flight response would exceed FIFO_DEPTH. No overflow under any `out_ready` pattern.

## Structure
- `glb_pkg`: `GLB_WORD_BYTES`=4, `glb_addr_t`, and the `rd_state_e` enum (IDLE/RUN/FIN). These are shared with the GLB and the future loader block.
- Sub-module `sync_fifo` (parameterised DATA_W, DEPTH): full/empty/count flags and registered head.
- The top module holds the FSM, address/count registers and credit logic.

## Test plan
- Basic read: GLB preloaded with bytes 00..1F; base=0x0, N=8, `out_ready`=1.
  - Stream is 0x03020100, 0x07060504 … 0x1F1E1D1C.
  - `out_last` on the 8th word; `done` at T+11.
- Backpressure: same data, `out_ready` toggling 1,0,0,1 repeating.
  - All 8 words arrive in order, none duplicated or dropped.
  - `glb_re` never issues while FIFO full + in-flight = 2.
- Zero count: N=0.
  - No `glb_re`, no `out_valid`; `done` exactly at T+2.
- Address wrap: ADDR_W=8, base=0xF8, N=4.
  - `glb_addr` sequence is F8, FC, 00, 04.
- Start-while-busy: second `start` with base=0x40, N=3 during an N=8 transfer.
  - Ignored; exactly 8 words from the original base; single `done`.
- Mid-transfer reset: `rst` asserted after 3 handshakes with `out_ready`=1.
  - All outputs at reset values the next cycle; no `done`.
  - A new `start` afterwards (base=0x10, N=2) returns 0x13121110, 0x17161514.
